// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and stream framing constants for the program loader.
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE, ERR} state_e;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into 32-bit words, flagging the byte that completes a word.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  localparam int IW = $clog2(BYTES_PER_WORD);
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  always_comb begin
    asm_d = asm_q;
    asm_d[{idx_q, 3'b000} +: 8] = data_i;
    idx_d = idx_q + 1'b1;
  end
  // the completed word is presented combinationally so the top can register it as the write
  assign word_valid_o = en_i && idx_q == IW'(BYTES_PER_WORD - 1);
  assign word_o = asm_d;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (en_i) begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: parses a UART header plus little-endian words and writes them into program memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e state_q;
  logic [15:0] n_q;
  logic [ADDR_W-1:0] wcnt_q, waddr_q;
  logic [TW-1:0] tmo_q;
  logic [31:0] wdata_q, word;
  logic wen_q, done_q, err_q, word_valid, in_session;
  logic [15:0] n_hdr;
  assign in_session = state_q == HDR0 || state_q == HDR1 || state_q == DATA;
  assign n_hdr = {rx_data, n_q[7:0]};
  byte_packer u_packer (
    .clk_i       (clock),
    .rst_i       (reset),
    .clr_i       (start_pg),
    .en_i        (rx_valid && state_q == DATA && !start_pg),
    .data_i      (rx_data),
    .word_valid_o(word_valid),
    .word_o      (word)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      if (start_pg) begin
        state_q <= HDR0;
        wcnt_q  <= '0;
        tmo_q   <= '0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else if (in_session) begin
        if (rx_valid) begin
          tmo_q <= '0;
          case (state_q)
            HDR0: begin
              n_q[7:0] <= rx_data;
              state_q  <= HDR1;
            end
            HDR1: begin
              n_q[15:8] <= rx_data;
              if (n_hdr == 16'd0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else if (32'(n_hdr) > (32'd1 << ADDR_W)) begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end else state_q <= DATA;
            end
            default: if (word_valid) begin
              wen_q   <= 1'b1;
              waddr_q <= wcnt_q;
              wdata_q <= word;
              wcnt_q  <= wcnt_q + 1'b1;
              if (32'(wcnt_q) + 32'd1 == 32'(n_q)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          endcase
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end else tmo_q <= tmo_q + 1'b1;
      end
    end
  end
  assign wen = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy = in_session;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench driving directed UART byte streams into prog_loader.
module tb_prog_loader;
  localparam int AW = 4;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          last;
  } wr_t;
  logic clock = 1'b0, reset = 1'b1, start_pg = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic wen, busy, done, err;
  logic [AW-1:0] waddr;
  logic [31:0] wdata;
  int errors = 0, checks = 0;
  wr_t exp_q[$];
  prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(50)) dut (
    .clock(clock), .reset(reset), .start_pg(start_pg), .rx_valid(rx_valid), .rx_data(rx_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (!reset && wen) begin
      wr_t e, a;
      checks++;
      a = '{addr: waddr, data: wdata, last: done};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wen: got addr=%0h data=%08h done=%0b, wanted no write", waddr, wdata, done);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%08h done=%0b, wanted addr=%0h data=%08h done=%0b",
                   a.addr, a.data, a.last, e.addr, e.data, e.last);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic start();
    start_pg = 1'b1;
    tick();
    start_pg = 1'b0;
  endtask
  initial begin
    #1;
    chk("reset_outputs", {wen, busy, done, err, 28'(waddr), wdata}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_not_busy", {busy, done, err}, 3'b000);
    // two-word image
    start();
    chk("busy_after_start", busy, 1'b1);
    exp_q.push_back('{addr: 4'd0, data: 32'h12345678, last: 1'b0});
    exp_q.push_back('{addr: 4'd1, data: 32'hDEADBEEF, last: 1'b1});
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("wen_after_word0", {wen, done}, 2'b10);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("final_write_cycle", {wen, done, busy, err}, 4'b1100);
    send(8'h99);
    tick();
    chk("done_sticky", {done, busy, wen}, 3'b100);
    // empty image
    start();
    chk("start_clears_done", {done, busy}, 2'b01);
    send(8'h00);
    chk("n0_after_hdr0", {done, busy}, 2'b01);
    send(8'h00);
    chk("n0_done", {done, busy, err, wen}, 4'b1000);
    // 17 words exceeds 16-word capacity
    start();
    send(8'h11); send(8'h00);
    chk("overflow_err", {err, busy, done}, 3'b100);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("err_sticky", {err, busy, wen}, 3'b100);
    // exactly-16 words is accepted
    start();
    send(8'h10); send(8'h00);
    chk("n16_accepted", {err, busy}, 2'b01);
    // timeout after two data bytes of a one-word image
    start();
    chk("start_clears_err", {err, busy}, 2'b01);
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    for (int i = 0; i < 49; i++) tick();
    chk("timeout_49", {err, busy}, 2'b01);
    tick();
    chk("timeout_50", {err, busy, done}, 3'b100);
    // start collides with the third data byte
    start();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    start_pg = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h33;
    tick();
    start_pg = 1'b0;
    rx_valid = 1'b0;
    chk("restart_hdr0", {busy, done, err, wen}, 4'b1000);
    exp_q.push_back('{addr: 4'd0, data: 32'h44332211, last: 1'b1});
    send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("restart_load_done", {wen, done, busy}, 3'b110);
    // asynchronous reset mid-word
    start();
    send(8'h01); send(8'h00); send(8'h55); send(8'h66); send(8'h77);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {wen, busy, done, err, 28'(waddr), wdata}, 64'd0);
    tick();
    reset = 1'b0;
    start();
    exp_q.push_back('{addr: 4'd0, data: 32'hDDCCBBAA, last: 1'b1});
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("post_reset_done", {wen, done, busy}, 3'b110);
    tick();
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
